// File: rtl/full_adder_pkg.sv
// Shared types and limits for the clocked 1-bit full adder cell.
package full_adder_pkg;

  typedef logic [1:0] fa_res_t;  // {cout,sum}

  localparam fa_res_t FA_RES_ZERO = 2'b00;
  localparam int      PIPE_MAX    = 4;

  function automatic fa_res_t fa_pack(input logic c, input logic s);
    return {c, s};
  endfunction

endpackage

// File: rtl/full_adder_comb.sv
// Purely combinational 1-bit full adder core: s = a^b^cin, c = majority(a,b,cin).
module full_adder_comb (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder_1bit_sync.sv
// Clocked 1-bit full adder with PIPE_STAGES-deep result register.
// Define FA_INPUT_REG_EN to register a, b, cin ahead of the core (adds one cycle of latency).
module full_adder_1bit_sync
  import full_adder_pkg::*;
#(
  parameter fa_res_t OUT_RST_VAL = FA_RES_ZERO,
  parameter int      PIPE_STAGES = 1
) (
  input  logic cin,
  input  logic a,
  input  logic b,
  input  logic clk,
  output logic sum,
  output logic cout,
  input  logic rst
);

  if (PIPE_STAGES < 1 || PIPE_STAGES > PIPE_MAX) begin : g_bad_depth
    $fatal(1, "full_adder_1bit_sync: PIPE_STAGES must be in 1..%0d", PIPE_MAX);
  end

  logic cin_core;
  logic a_core;
  logic b_core;

`ifdef FA_INPUT_REG_EN
  logic [2:0] in_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_reg <= 3'b000;
    end else begin
      in_reg <= {cin, a, b};
    end
  end

  assign {cin_core, a_core, b_core} = in_reg;
`else
  assign cin_core = cin;
  assign a_core   = a;
  assign b_core   = b;
`endif

  logic    s_core;
  logic    c_core;
  fa_res_t core_res;

  full_adder_comb u_core (
    .a   (a_core),
    .b   (b_core),
    .cin (cin_core),
    .s   (s_core),
    .c   (c_core)
  );

  assign core_res = fa_pack(c_core, s_core);

  fa_res_t [PIPE_STAGES-1:0] pipe_reg;
  fa_res_t [PIPE_STAGES-1:0] pipe_next;

  // Stage 0 takes the fresh core result; later stages shift the previous one forward.
  genvar gi;
  for (gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign pipe_next[gi] = core_res;
    end else begin : g_shift
      assign pipe_next[gi] = pipe_reg[gi-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_reg <= {PIPE_STAGES{OUT_RST_VAL}};
    end else begin
      pipe_reg <= pipe_next;
    end
  end

  assign {cout, sum} = pipe_reg[PIPE_STAGES-1];

endmodule

// File: tb/tb_full_adder_1bit_sync.sv
// Scoreboard bench for full_adder_1bit_sync: driver queues expected results, monitor checks per edge.
module tb_full_adder_1bit_sync;

  localparam int PIPE = 3;
`ifdef FA_INPUT_REG_EN
  localparam int LAT = PIPE + 1;
`else
  localparam int LAT = PIPE;
`endif
  localparam logic [1:0] RST_VAL = 2'b00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cin = 1'b0;
  logic a   = 1'b0;
  logic b   = 1'b0;
  logic sum;
  logic cout;

  full_adder_1bit_sync #(
    .OUT_RST_VAL (RST_VAL),
    .PIPE_STAGES (PIPE)
  ) dut (
    .cin  (cin),
    .a    (a),
    .b    (b),
    .clk  (clk),
    .sum  (sum),
    .cout (cout),
    .rst  (rst)
  );

  always #15 clk = ~clk;

  typedef struct {
    int         edge_no;
    logic [1:0] exp;     // {cout,sum}
    string      name;
  } sb_entry_t;

  sb_entry_t sb[$];
  int edge_cnt = 0;
  int checks   = 0;
  int errors   = 0;

  // Monitor: after every rising edge, compare every entry due on that edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      edge_cnt++;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].edge_no <= edge_cnt) begin
          checks++;
          if (sb[i].edge_no < edge_cnt || {cout, sum} !== sb[i].exp) begin
            errors++;
            $display("FAIL %s edge %0d: got cout,sum=%b%b required %b%b (due edge %0d)",
                     sb[i].name, edge_cnt, cout, sum, sb[i].exp[1], sb[i].exp[0], sb[i].edge_no);
          end else begin
            $display("ok   %s edge %0d: cout,sum=%b%b", sb[i].name, edge_cnt, cout, sum);
          end
          sb.delete(i);
        end
      end
    end
  end

  // Driver: set inputs mid-cycle, queue the hand-computed result for the edge it should appear on.
  task automatic step(input string name, input logic r, input logic ci, input logic ai,
                      input logic bi, input logic es, input logic ec, input bit glitch);
    int e;
    sb_entry_t ent;
    @(negedge clk);
    rst = r;
    cin = ci;
    a   = ai;
    b   = bi;
    e   = edge_cnt + 1;
    if (r) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].edge_no >= e) sb.delete(i);
      end
      for (int k = 0; k < LAT; k++) begin
        ent.edge_no = e + k;
        ent.exp     = RST_VAL;
        ent.name    = name;
        sb.push_back(ent);
      end
    end else begin
      ent.edge_no = e + LAT - 1;
      ent.exp     = {ec, es};
      ent.name    = name;
      sb.push_back(ent);
    end
    if (glitch) begin
      #3 a = ~a;
      #3 a = ~a;
    end
  endtask

  // Truth table rows indexed by {cin,a,b}: {sum,cout}
  logic [1:0] tt [8] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

  initial begin
    logic [2:0] v;
    // Reset with all inputs high
    step("reset", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Exhaustive sweep
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      step($sformatf("sweep_%b", v), 1'b0, v[2], v[1], v[0], tt[i][1], tt[i][0], 1'b0);
    end

    // Cumulative sequence: a=1, b=1, cin=1, a=b=0, a=1 & cin=0
    step("seq_a",    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("seq_ab",   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step("seq_abc",  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("seq_c",    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("seq_a2",   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Isolated pulse to pin down exact latency
    step("zero_pre", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lat_011",  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step("zero_post",1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // a pulses 0->1->0 between edges: only b=1 is seen
    step("glitch_1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step("glitch_2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Mid-stream reset with 111 in flight
    step("inflight", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("inflight", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("mid_rst",  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    // First sample after reset must be fresh
    step("fresh_110",1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step("fresh_001",1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Drain, then every queued expectation must have been consumed
    repeat (LAT + 2) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
